fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined core. It generates the PC, issues requests to a synchronous-read instruction memory with 1-cycle latency, and drives the IF/ID pipeline register with a valid bit. Supports hazard stall with a skid buffer for the in-flight word, and branch redirect with flush. Sits between the PC-redirect logic (EX/branch unit) and the decode stage.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 29 ++
 rtl/fetch_skid_buf.sv | 43 ++++
 rtl/fetch_stage.sv | 116 +++++++++++
 tb/tb_fetch_stage.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared defaults and helpers for the instruction-fetch stage.
//   DEF_* : default parameter values for fetch_stage
//   addr_lsb() : log2 of the fetch granule, i.e. the number of forced-zero PC bits
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_INST_W     = 32;
    localparam int unsigned DEF_INST_BYTES = 4;
    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INST   = 32'h0000_0013;

    // log2 of a power-of-two byte count; 0 for non-powers-of-two
    function automatic int unsigned addr_lsb(input int unsigned bytes);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) == 64'(bytes)) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: redirect/stall controls, instruction memory port,
// and the IF/ID pipeline register outputs.
//   master : the fetch stage (drives imem_* requests and if_id_*)
//   slave  : the surrounding core / memory
interface fetch_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned INST_W = 32
);
    logic              pc_src;
    logic [ADDR_W-1:0] branch_target;
    logic              hazard;
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              if_id_valid;
    logic [ADDR_W-1:0] if_id_pc;
    logic [ADDR_W-1:0] if_id_pc_next;
    logic [INST_W-1:0] if_id_inst;

    modport master (
        input  pc_src, branch_target, hazard, imem_rdata,
        output imem_en, imem_addr, if_id_valid, if_id_pc, if_id_pc_next, if_id_inst
    );

    modport slave (
        output pc_src, branch_target, hazard, imem_rdata,
        input  imem_en, imem_addr, if_id_valid, if_id_pc, if_id_pc_next, if_id_inst
    );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for the word returned by memory while the stage
// is stalled (memory data is only valid for one cycle after the read).
//   clk, rst   : clock, synchronous active-high reset
//   capture    : load rdata into the buffer
//   clear      : drop the buffered word
//   rdata      : live memory read data
//   skid_valid : buffer holds a word
//   inst_c     : buffered word if present, else live read data (combinational)
module fetch_skid_buf #(
    parameter int unsigned INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              capture,
    input  logic              clear,
    input  logic [INST_W-1:0] rdata,
    output logic              skid_valid,
    output logic [INST_W-1:0] inst_c
);

    logic [INST_W-1:0] skid_inst;

    // Valid flag: reset/clear dominate capture
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            skid_valid <= 1'b0;
        end else if (capture) begin
            skid_valid <= 1'b1;
        end
    end

    // Data only changes on capture; contents are don't-care while invalid
    always_ff @(posedge clk) begin
        if (rst) begin
            skid_inst <= '0;
        end else if (capture) begin
            skid_inst <= rdata;
        end
    end

    assign inst_c = skid_valid ? skid_inst : rdata;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC generation, 1-cycle-latency instruction memory
// request, IF/ID register with valid bit, stall skid buffer, branch redirect.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_if.master (pc_src/branch_target/hazard in, imem_* request
//              and read data, if_id_* pipeline register out)
// imem_en / imem_addr are combinational so a redirect issues in the same cycle.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W     = DEF_ADDR_W,
    parameter int unsigned       INST_W     = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned       INST_BYTES = DEF_INST_BYTES,
    parameter logic [INST_W-1:0] NOP_INST   = INST_W'(DEF_NOP_INST)
) (
    input logic    clk,
    input logic    rst,
    fetch_if.master bus
);

    localparam int unsigned       ADDR_LSB   = addr_lsb(INST_BYTES);
    localparam logic [ADDR_W-1:0] LSB_MASK   = ADDR_W'((64'(1) << ADDR_LSB) - 64'(1));
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~LSB_MASK;
    localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;

    logic [ADDR_W-1:0] pc,            pc_d;
    logic              req_valid,     req_valid_d;
    logic [ADDR_W-1:0] req_pc,        req_pc_d;
    logic              if_id_valid,   if_id_valid_d;
    logic [ADDR_W-1:0] if_id_pc,      if_id_pc_d;
    logic [ADDR_W-1:0] if_id_pc_next, if_id_pc_next_d;
    logic [INST_W-1:0] if_id_inst,    if_id_inst_d;

    logic [ADDR_W-1:0] fetch_addr;
    logic              stall;
    logic              skid_valid;
    logic              skid_capture;
    logic [INST_W-1:0] sel_inst;

    // Request issue; redirect overrides the sequential PC in the same cycle
    assign fetch_addr    = bus.pc_src ? (bus.branch_target & ALIGN_MASK) : pc;
    assign stall         = bus.hazard && !bus.pc_src;
    assign bus.imem_addr = fetch_addr;
    assign bus.imem_en   = !rst && (bus.pc_src || !bus.hazard);

    // Grab the in-flight word on the first stalled cycle; any non-stall cycle
    // either consumes it (normal) or discards it (redirect)
    assign skid_capture = stall && req_valid && !skid_valid;

    fetch_skid_buf #(
        .INST_W (INST_W)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .capture    (skid_capture),
        .clear      (!stall),
        .rdata      (bus.imem_rdata),
        .skid_valid (skid_valid),
        .inst_c     (sel_inst)
    );

    // Next-state: redirect > stall (hold) > normal advance
    always_comb begin
        pc_d            = pc;
        req_valid_d     = req_valid;
        req_pc_d        = req_pc;
        if_id_valid_d   = if_id_valid;
        if_id_pc_d      = if_id_pc;
        if_id_pc_next_d = if_id_pc_next;
        if_id_inst_d    = if_id_inst;

        if (bus.pc_src) begin
            pc_d          = fetch_addr + PC_INC;
            req_valid_d   = 1'b1;
            req_pc_d      = fetch_addr;
            if_id_valid_d = 1'b0;
            if_id_inst_d  = NOP_INST;
        end else if (!bus.hazard) begin
            pc_d            = fetch_addr + PC_INC;
            req_valid_d     = 1'b1;
            req_pc_d        = fetch_addr;
            if_id_valid_d   = req_valid;
            if_id_pc_d      = req_pc;
            if_id_pc_next_d = req_pc + PC_INC;
            if_id_inst_d    = req_valid ? sel_inst : NOP_INST;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= PC_RST;
            req_valid     <= 1'b0;
            req_pc        <= '0;
            if_id_valid   <= 1'b0;
            if_id_pc      <= '0;
            if_id_pc_next <= '0;
            if_id_inst    <= NOP_INST;
        end else begin
            pc            <= pc_d;
            req_valid     <= req_valid_d;
            req_pc        <= req_pc_d;
            if_id_valid   <= if_id_valid_d;
            if_id_pc      <= if_id_pc_d;
            if_id_pc_next <= if_id_pc_next_d;
            if_id_inst    <= if_id_inst_d;
        end
    end

    assign bus.if_id_valid   = if_id_valid;
    assign bus.if_id_pc      = if_id_pc;
    assign bus.if_id_pc_next = if_id_pc_next;
    assign bus.if_id_inst    = if_id_inst;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: two instances (RESET_PC 0 and
// 0xFFFFFFF8), each with a synchronous memory model returning word = address
// and a poison word when not enabled.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] POISON = 32'hDEAD_BEEF;

    logic clk;
    logic rst0;
    logic rst1;
    int   errors;
    int   checks;

    fetch_if #(.ADDR_W(32), .INST_W(32)) bus0 ();
    fetch_if #(.ADDR_W(32), .INST_W(32)) bus1 ();

    fetch_stage #(
        .ADDR_W     (32),
        .INST_W     (32),
        .RESET_PC   (32'h0000_0000),
        .INST_BYTES (4),
        .NOP_INST   (NOP)
    ) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    fetch_stage #(
        .ADDR_W     (32),
        .INST_W     (32),
        .RESET_PC   (32'hFFFF_FFF8),
        .INST_BYTES (4),
        .NOP_INST   (NOP)
    ) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus0.imem_rdata <= bus0.imem_en ? bus0.imem_addr : POISON;
        bus1.imem_rdata <= bus1.imem_en ? bus1.imem_addr : POISON;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic ifid0(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, 32'(bus0.if_id_valid), 32'(v));
        chk({tag, ".pc"},    bus0.if_id_pc,   pc);
        chk({tag, ".inst"},  bus0.if_id_inst, inst);
    endtask

    task automatic ifid1(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] inst);
        chk({tag, ".valid"}, 32'(bus1.if_id_valid), 32'(v));
        chk({tag, ".pc"},    bus1.if_id_pc,   pc);
        chk({tag, ".inst"},  bus1.if_id_inst, inst);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk    = 1'b0;
        errors = 0;
        checks = 0;
        rst0   = 1'b1;
        rst1   = 1'b1;
        bus0.pc_src = 1'b0; bus0.hazard = 1'b0; bus0.branch_target = '0;
        bus1.pc_src = 1'b0; bus1.hazard = 1'b0; bus1.branch_target = '0;

        // Reset state
        tick();
        tick();
        chk("rst.valid",   32'(bus0.if_id_valid), 32'd0);
        chk("rst.inst",    bus0.if_id_inst, NOP);
        chk("rst.pc",      bus0.if_id_pc, 32'h0);
        chk("rst.pc_next", bus0.if_id_pc_next, 32'h0);
        chk("rst.en0",     32'(bus0.imem_en), 32'd0);
        chk("rst.en1",     32'(bus1.imem_en), 32'd0);

        // Release and stream
        rst0 = 1'b0;
        #1;
        chk("rel.en",   32'(bus0.imem_en), 32'd1);
        chk("rel.addr", bus0.imem_addr, 32'h0);
        tick();
        chk("c1.valid", 32'(bus0.if_id_valid), 32'd0);
        chk("c1.addr",  bus0.imem_addr, 32'h4);
        tick();
        ifid0("c2", 1'b1, 32'h0, 32'h0);
        chk("c2.pc_next", bus0.if_id_pc_next, 32'h4);
        chk("c2.addr",    bus0.imem_addr, 32'h8);
        tick();
        ifid0("c3", 1'b1, 32'h4, 32'h4);

        // Three-cycle stall with pc 8 in flight
        bus0.hazard = 1'b1;
        #1;
        chk("stall.en", 32'(bus0.imem_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            ifid0("stall.hold", 1'b1, 32'h4, 32'h4);
            chk("stall.en_hold", 32'(bus0.imem_en), 32'd0);
        end
        bus0.hazard = 1'b0;
        #1;
        chk("unstall.en",   32'(bus0.imem_en), 32'd1);
        chk("unstall.addr", bus0.imem_addr, 32'hC);
        tick();
        ifid0("unstall.skid", 1'b1, 32'h8, 32'h8);
        tick();
        ifid0("unstall.next", 1'b1, 32'hC, 32'hC);
        chk("unstall.pc_next", bus0.if_id_pc_next, 32'h10);

        // Redirect to 0x100
        bus0.pc_src = 1'b1;
        bus0.branch_target = 32'h100;
        #1;
        chk("br.addr", bus0.imem_addr, 32'h100);
        chk("br.en",   32'(bus0.imem_en), 32'd1);
        tick();
        chk("br.flush.valid", 32'(bus0.if_id_valid), 32'd0);
        chk("br.flush.inst",  bus0.if_id_inst, NOP);
        bus0.pc_src = 1'b0;
        #1;
        chk("br.seq_addr", bus0.imem_addr, 32'h104);
        tick();
        ifid0("br.tgt", 1'b1, 32'h100, 32'h100);
        tick();
        ifid0("br.tgt4", 1'b1, 32'h104, 32'h104);

        // Redirect and hazard together
        bus0.pc_src = 1'b1;
        bus0.hazard = 1'b1;
        bus0.branch_target = 32'h200;
        #1;
        chk("brhz.en",   32'(bus0.imem_en), 32'd1);
        chk("brhz.addr", bus0.imem_addr, 32'h200);
        tick();
        chk("brhz.flush.valid", 32'(bus0.if_id_valid), 32'd0);
        chk("brhz.flush.inst",  bus0.if_id_inst, NOP);
        bus0.pc_src = 1'b0;
        #1;
        chk("brhz.stall_en", 32'(bus0.imem_en), 32'd0);
        tick();
        chk("brhz.hold.valid", 32'(bus0.if_id_valid), 32'd0);
        bus0.hazard = 1'b0;
        tick();
        ifid0("brhz.tgt", 1'b1, 32'h200, 32'h200);
        chk("brhz.pc_next", bus0.if_id_pc_next, 32'h204);
        tick();
        ifid0("brhz.tgt4", 1'b1, 32'h204, 32'h204);

        // Unaligned target
        bus0.pc_src = 1'b1;
        bus0.branch_target = 32'h103;
        #1;
        chk("align.addr", bus0.imem_addr, 32'h100);
        tick();
        bus0.pc_src = 1'b0;
        tick();
        ifid0("align.tgt", 1'b1, 32'h100, 32'h100);
        chk("align.seq_addr", bus0.imem_addr, 32'h108);
        rst0 = 1'b1;

        // High reset PC with address wrap
        rst1 = 1'b0;
        #1;
        chk("wrap.addr0", bus1.imem_addr, 32'hFFFF_FFF8);
        chk("wrap.en",    32'(bus1.imem_en), 32'd1);
        tick();
        chk("wrap.addr1", bus1.imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap.addr2", bus1.imem_addr, 32'h0);
        ifid1("wrap.i0", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
        chk("wrap.i0.pc_next", bus1.if_id_pc_next, 32'hFFFF_FFFC);
        tick();
        ifid1("wrap.i1", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("wrap.i1.pc_next", bus1.if_id_pc_next, 32'h0);
        chk("wrap.addr3", bus1.imem_addr, 32'h4);
        tick();
        ifid1("wrap.i2", 1'b1, 32'h0, 32'h0);
        chk("wrap.i2.pc_next", bus1.if_id_pc_next, 32'h4);

        // Reset during a stall discards skid and in-flight request
        bus1.hazard = 1'b1;
        tick();
        ifid1("rststall.hold", 1'b1, 32'h0, 32'h0);
        rst1 = 1'b1;
        #1;
        chk("rststall.en", 32'(bus1.imem_en), 32'd0);
        tick();
        chk("rststall.valid",   32'(bus1.if_id_valid), 32'd0);
        chk("rststall.inst",    bus1.if_id_inst, NOP);
        chk("rststall.pc_next", bus1.if_id_pc_next, 32'h0);
        rst1 = 1'b0;
        bus1.hazard = 1'b0;
        #1;
        chk("rststall.addr", bus1.imem_addr, 32'hFFFF_FFF8);
        tick();
        chk("rststall.bubble", 32'(bus1.if_id_valid), 32'd0);
        tick();
        ifid1("rststall.first", 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFF8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
